fp32_to_fp16_pipe: RTL
======================

Name: fp32_to_fp16_pipe

Overview:
Pipelined IEEE-754 binary32 to binary16 narrowing converter with round-to-nearest-even. It is the write-back counterpart of the fp16-to-fp32 widening path: accumulator and softmax results held in fp32 are narrowed to fp16 before storage. It uses valid/ready handshakes on both sides, sustains one result per cycle, and reports per-result exception flags plus sticky status flags.

Parameters:
FTZ, 0, 1 = results that would be fp16 subnormal are flushed to signed zero; 0 = gradual underflow.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  in_fp32 is valid
in_ready  out  1  block accepts in_fp32 this cycle
in_fp32  in  32  binary32 operand
out_valid  out  1  out_fp16 and out_flags are valid
out_ready  in  1  downstream accepts the output
out_fp16  out  16  binary16 result
out_flags  out  4  {invalid, overflow, underflow, inexact} for out_fp16
flags_clr  in  1  clears sticky_flags
sticky_flags  out  4  OR of out_flags over all accepted outputs since reset or clear

Behaviour:
- Reset (async, rst=1): both stage valids=0; out_valid=0, out_fp16=0, out_flags=0, sticky_flags=0. in_ready=1 immediately after release. A conversion in flight when rst asserts is discarded.
- Pipeline enable: en = !out_valid | out_ready; in_ready = en. Both stages advance only when en=1. Stage 1 (S1) loads when in_valid & in_ready. Stage 2 (S2) loads from S1.
- Latency is 2 cycles from accept to out_valid with no backpressure. Throughput is 1 per cycle. While stalled, out_fp16 and out_flags hold stable.
- S1 classifies the input (s, e = bits[30:23], f = bits[22:0]) and registers the sign, the class, the candidate exponent and 11-bit mantissa, guard, round/sticky, and the early flags.
- S2 performs rounding and packing.
- Classes and results:
  - e=255, f!=0 (NaN): {s,5'h1F,1,f[21:13]}. Quiet bit forced, payload truncated. invalid=1 if f[22]=0 (sNaN). No other flags.
  - e=255, f=0: {s,5'h1F,10'h0}. No flags.
  - e=0 (zero or fp32 subnormal): {s,15'h0}. If f!=0 then underflow=1 and inexact=1.
  - e>=143: {s,5'h1F,0}, overflow=1, inexact=1.
  - 113<=e<=142 (normal): exp16=e-112, mant=f[22:13], G=f[12], S=|f[11:0]. Round up if G&(S|mant[0]). Mantissa carry increments exp16. If exp16 reaches 31, the result is inf with overflow=1. inexact=G|S.
  - e<=112 (subnormal result): sig={1,f} (24 bits) shifted right by 126-e. Shifts >=26 collapse to m=0, G=0, S=1. Round to nearest even on m. A carry to 1024 yields 0x0400 (smallest normal), so no special case is needed. underflow=inexact=(G|S). Tininess is detected before rounding. If FTZ=1: result {s,15'h0}, underflow=1, inexact=1.
- Flags are exclusive apart from the overflow/underflow+inexact pairs.
- sticky_flags next value = (flags_clr ? 0 : sticky_flags) | ((out_valid & out_ready) ? out_flags : 0). If clear and a handshake occur in the same cycle, the new flags survive.
- The sign is always preserved, including for zero and inf.

Test Plan:
- 0x3F800000 -> 0x3C00, flags 0. 0xC0490FDB -> 0xC248, inexact.
- 0x477FE000 -> 0x7BFF, flags 0. 0x477FF000 -> 0x7C00, overflow+inexact. 0xFF800000 -> 0xFC00, flags 0.
- Ties: 0x3F801000 -> 0x3C00 inexact (tie to even). 0x3F803000 -> 0x3C02 inexact.
- Subnormals, FTZ=0:
  - 0x33800000 -> 0x0001, flags 0.
  - 0x33000000 -> 0x0000, underflow+inexact.
  - 0x387FE000 -> 0x0400, underflow+inexact.
  - 0x80000001 -> 0x8000, underflow+inexact.
  - With FTZ=1, 0x33800000 -> 0x0000, underflow+inexact.
- NaN: 0x7FC00000 -> 0x7E00, flags 0. 0x7F800001 -> 0x7E00, invalid. Then pulse flags_clr with no handshake -> sticky_flags=0.
- Backpressure: stream 8 back-to-back inputs while out_ready toggles 1,0,0,1,... -> outputs in order with none lost or duplicated; in_ready=0 exactly while out_valid & !out_ready; data stable during the stall. Assert rst mid-stream -> out_valid=0 asynchronously and no stale output after release.

Source files
------------

// File: rtl/fp32_to_fp16_pipe.sv
// fp32_to_fp16_pipe: two-stage binary32 -> binary16 narrowing converter,
// round-to-nearest-even, valid/ready on both sides, per-result and sticky flags.
// Flag vectors are {invalid, overflow, underflow, inexact}.
module fp32_to_fp16_pipe #(
  parameter int unsigned FTZ = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_fp32,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_fp16,
  output logic [3:0]  out_flags,
  input  logic        flags_clr,
  output logic [3:0]  sticky_flags
);

  // PASS: result fully formed in stage 1 (NaN, inf, zero, overflow, flushed)
  // NORM: normal fp16 result needing rounding
  // SUB:  subnormal fp16 result needing rounding
  typedef enum logic [1:0] {
    CLS_PASS = 2'd0,
    CLS_NORM = 2'd1,
    CLS_SUB  = 2'd2
  } cls_t;

  logic        en;
  logic [7:0]  e;
  logic [22:0] f;
  logic [7:0]  sub_shift;
  logic [35:0] shifted;

  cls_t        c_cls;
  logic [4:0]  c_exp;
  logic [10:0] c_mant;
  logic        c_g;
  logic        c_st;
  logic [3:0]  c_fl;

  logic        s1_valid;
  logic        s1_sign;
  cls_t        s1_cls;
  logic [4:0]  s1_exp;
  logic [10:0] s1_mant;
  logic        s1_g;
  logic        s1_st;
  logic [3:0]  s1_fl;

  logic        round_up;
  logic [11:0] sum;
  logic [15:0] r_res;
  logic [3:0]  r_fl;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign e = in_fp32[30:23];
  assign f = in_fp32[22:0];

  // Subnormal path: the total right shift of {1,f} is 126-e (>= 14 here).
  // The fixed 14 bits are absorbed by indexing, so only 112-e (0..11) is a
  // real shifter; the 12 zero pad bits catch what falls off for sticky.
  assign sub_shift = 8'd112 - e;
  assign shifted   = {1'b1, f, 12'b0} >> sub_shift[3:0];

  // Stage 1 classification and candidate fields
  always_comb begin
    c_cls  = CLS_PASS;
    c_exp  = '0;
    c_mant = '0;
    c_g    = 1'b0;
    c_st   = 1'b0;
    c_fl   = '0;
    if (e == 8'hFF) begin
      c_exp = 5'h1F;
      if (f != '0) begin
        c_mant  = {2'b01, f[21:13]};
        c_fl[3] = ~f[22];
      end
    end else if (e == 8'h00) begin
      if (f != '0) c_fl = 4'b0011;
    end else if (e >= 8'd143) begin
      c_exp = 5'h1F;
      c_fl  = 4'b0101;
    end else if (e >= 8'd113) begin
      c_cls  = CLS_NORM;
      // e-112 for e in 113..142 equals e[4:0]+16 mod 32, i.e. flip bit 4
      c_exp  = {~e[4], e[3:0]};
      c_mant = {1'b1, f[22:13]};
      c_g    = f[12];
      c_st   = |f[11:0];
    end else if (FTZ != 0) begin
      c_fl = 4'b0011;
    end else begin
      c_cls = CLS_SUB;
      if (sub_shift >= 8'd12) begin
        c_st = 1'b1;
      end else begin
        c_mant = {1'b0, shifted[35:26]};
        c_g    = shifted[25];
        c_st   = |shifted[24:0];
      end
    end
  end

  // Stage 1 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= CLS_PASS;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_g     <= 1'b0;
      s1_st    <= 1'b0;
      s1_fl    <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_fp32[31];
        s1_cls  <= c_cls;
        s1_exp  <= c_exp;
        s1_mant <= c_mant;
        s1_g    <= c_g;
        s1_st   <= c_st;
        s1_fl   <= c_fl;
      end
    end
  end

  // Stage 2 rounding and packing
  always_comb begin
    round_up = s1_g && (s1_st || s1_mant[0]);
    sum      = {1'b0, s1_mant} + {11'b0, round_up};
    r_res    = {s1_sign, s1_exp, s1_mant[9:0]};
    r_fl     = s1_fl;
    case (s1_cls)
      CLS_NORM: begin
        // carry out of the hidden bit bumps the exponent; 30 -> 31 lands on inf
        r_res = {s1_sign, s1_exp + {4'b0, sum[11]}, sum[9:0]};
        r_fl  = {1'b0, (s1_exp == 5'd30) && sum[11], 1'b0, s1_g || s1_st};
      end
      CLS_SUB: begin
        // a carry into bit 10 naturally encodes the smallest normal
        r_res = {s1_sign, 4'b0, sum[10:0]};
        r_fl  = {2'b00, s1_g || s1_st, s1_g || s1_st};
      end
      default: ;
    endcase
  end

  // Stage 2 / output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_fp16  <= '0;
      out_flags <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_fp16  <= r_res;
        out_flags <= r_fl;
      end
    end
  end

  // Sticky status: a clear coinciding with a handshake keeps the new flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
    end else begin
      sticky_flags <= (flags_clr ? 4'b0 : sticky_flags) |
                      ((out_valid && out_ready) ? out_flags : 4'b0);
    end
  end

endmodule
